// File: rtl/dcache_wb.sv
// Direct-mapped write-back data cache with registered req/ack line transfers and whole-cache flush.
// Define DCACHE_STATS_EN to enable the saturating hit_cnt/miss_cnt counters (tied to 0 otherwise).
module dcache_wb #(
    parameter int unsigned N     = 64,
    parameter int unsigned ADDR  = 32,
    parameter int unsigned LINES = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 memread,
    input  logic [1:0]                           memwrite,
    input  logic                                 dword,
    input  logic [ADDR-1:0]                      dataadr,
    input  logic [N-1:0]                         writedata,
    output logic [N-1:0]                         readdata,
    output logic                                 ready,
    input  logic                                 flush,
    output logic                                 flush_done,
    output logic                                 mem_req,
    output logic                                 mem_we,
    output logic [ADDR-$clog2(N/8*WORDS)-1:0]    mem_addr,
    output logic [N*WORDS-1:0]                   mem_wdata,
    input  logic [N*WORDS-1:0]                   mem_rdata,
    input  logic                                 mem_ack,
    output logic [31:0]                          hit_cnt,
    output logic [31:0]                          miss_cnt
);
    localparam int unsigned OFF  = $clog2(N / 8 * WORDS);
    localparam int unsigned IDX  = $clog2(LINES);
    localparam int unsigned TAG  = ADDR - OFF - IDX;
    localparam int unsigned LW   = N * WORDS;
    localparam int unsigned WSEL = OFF - 3;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StWb      = 3'd1;
    localparam logic [2:0] StFill    = 3'd2;
    localparam logic [2:0] StFlush   = 3'd3;
    localparam logic [2:0] StFlushWb = 3'd4;

    localparam logic [IDX-1:0] LastIdx  = IDX'(LINES - 1);
    localparam logic [N-1:0]   ByteMask = N'(8'hFF);
    localparam logic [LW-1:0]  WordMask = LW'({N{1'b1}});

    logic [2:0]            state_q;
    logic [LINES-1:0]      valid_q, dirty_q;
    logic [TAG-1:0]        tag_q  [LINES];
    logic [LW-1:0]         data_q [LINES];
    logic [IDX-1:0]        flush_idx_q;
    logic                  mem_req_q, mem_we_q;
    logic [ADDR-OFF-1:0]   mem_addr_q;
    logic [LW-1:0]         mem_wdata_q;

    logic [TAG-1:0]        tag;
    logic [IDX-1:0]        idx;
    logic [WSEL-1:0]       wsel;
    logic                  req, store, hit, ack;
    logic [LW-1:0]         line, line_merged;
    logic [N-1:0]          dw_cur, dw_new;
    int unsigned           wsh, bsh;

    assign tag   = dataadr[ADDR-1:OFF+IDX];
    assign idx   = dataadr[OFF+IDX-1:OFF];
    assign wsel  = dataadr[OFF-1:3];
    assign store = memwrite != 2'd0;
    assign req   = memread || store;
    assign hit   = valid_q[idx] && (tag_q[idx] == tag);
    assign ack   = mem_ack && mem_req_q;
    assign ready = (state_q == StIdle) && (!req || hit);

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // A dirty last line finishes on its write-back ack rather than on a revisit.
    assign flush_done = (flush_idx_q == LastIdx) &&
                        (((state_q == StFlush) && !dirty_q[flush_idx_q]) ||
                         ((state_q == StFlushWb) && ack));

    // Big-endian lane selection: word 0 and byte 0 sit at the most significant end.
    always_comb begin
        wsh    = (WORDS - 1 - 32'(wsel)) * N;
        bsh    = (7 - 32'(dataadr[2:0])) * 8;
        line   = data_q[idx];
        dw_cur = N'(line >> wsh);
        dw_new = dw_cur;
        case (memwrite)
            2'd1: begin
                if (dataadr[2]) dw_new[31:0] = writedata[31:0];
                else            dw_new[N-1:N-32] = writedata[31:0];
            end
            2'd2:    dw_new = (dw_cur & ~(ByteMask << bsh)) | (N'(writedata[7:0]) << bsh);
            2'd3:    dw_new = writedata;
            default: dw_new = dw_cur;
        endcase
        line_merged = (line & ~(WordMask << wsh)) | (LW'(dw_new) << wsh);
        readdata    = dword ? dw_cur
                            : {{(N-32){1'b0}}, (dataadr[2] ? dw_cur[31:0] : dw_cur[N-1:N-32])};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            dirty_q     <= '0;
            flush_idx_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        if (hit) begin
                            if (store) dirty_q[idx] <= 1'b1;
                        end else if (valid_q[idx] && dirty_q[idx]) begin
                            state_q     <= StWb;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {tag_q[idx], idx};
                            mem_wdata_q <= line;
                        end else begin
                            state_q    <= StFill;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= dataadr[ADDR-1:OFF];
                        end
                    end else if (flush) begin
                        state_q     <= StFlush;
                        flush_idx_q <= '0;
                    end
                end
                StWb: begin
                    if (ack) begin
                        dirty_q[idx] <= 1'b0;
                        state_q      <= StFill;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= dataadr[ADDR-1:OFF];
                    end
                end
                StFill: begin
                    if (ack) begin
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        mem_req_q    <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                StFlush: begin
                    if (dirty_q[flush_idx_q]) begin
                        state_q     <= StFlushWb;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {tag_q[flush_idx_q], flush_idx_q};
                        mem_wdata_q <= data_q[flush_idx_q];
                    end else if (flush_idx_q == LastIdx) begin
                        state_q <= StIdle;
                    end else begin
                        flush_idx_q <= flush_idx_q + IDX'(1);
                    end
                end
                StFlushWb: begin
                    if (ack) begin
                        dirty_q[flush_idx_q] <= 1'b0;
                        mem_req_q            <= 1'b0;
                        mem_we_q             <= 1'b0;
                        if (flush_idx_q == LastIdx) state_q <= StIdle;
                        else begin
                            state_q     <= StFlush;
                            flush_idx_q <= flush_idx_q + IDX'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Line payload and tags carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == StIdle && req && hit && store) begin
                data_q[idx] <= line_merged;
            end else if (state_q == StFill && ack) begin
                data_q[idx] <= mem_rdata;
                tag_q[idx]  <= tag;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == StIdle && req) begin
            if (hit) begin
                if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
            end else if (miss_cnt_q != '1) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// Self-checking bench for dcache_wb: flat byte-memory reference model plus a randomised line memory.
module tb_dcache_wb;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          memread = 1'b0;
    logic [1:0]    memwrite = 2'd0;
    logic          dword = 1'b0;
    logic [31:0]   dataadr = '0;
    logic [63:0]   writedata = '0;
    logic [63:0]   readdata;
    logic          ready;
    logic          flush = 1'b0;
    logic          flush_done;
    logic          mem_req, mem_we;
    logic [26:0]   mem_addr;
    logic [255:0]  mem_wdata;
    logic [255:0]  mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic [31:0]   hit_cnt, miss_cnt;

    int checks = 0;
    int errors = 0;

    // Reference: CPU-visible byte memory plus abstract per-index cache bookkeeping.
    byte unsigned  fmem [1024];
    logic [255:0]  bmem [32];
    logic          cv [8];
    logic          cd [8];
    logic [23:0]   ct [8];
    int            exp_hits = 0;
    int            exp_miss = 0;

    int unsigned   ack_wait_max = 0;
    int unsigned   cur_wait = 0;
    bit            hold_ack = 1'b0;
    logic [26:0]   wb_addr_q [$];
    logic [255:0]  wb_data_q [$];
    logic [26:0]   fill_addr_q [$];

    dcache_wb dut (
        .clk        (clk),
        .reset      (reset),
        .memread    (memread),
        .memwrite   (memwrite),
        .dword      (dword),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .readdata   (readdata),
        .ready      (ready),
        .flush      (flush),
        .flush_done (flush_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    // Backing memory: acks after a random wait, one transfer per ack.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mem_req && !reset && !hold_ack) begin
            if (cur_wait == 0) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    bmem[mem_addr[4:0]] = mem_wdata;
                    wb_addr_q.push_back(mem_addr);
                    wb_data_q.push_back(mem_wdata);
                end else begin
                    mem_rdata = bmem[mem_addr[4:0]];
                    fill_addr_q.push_back(mem_addr);
                end
                cur_wait = $urandom_range(ack_wait_max, 0);
            end else begin
                cur_wait = cur_wait - 1;
            end
        end
    end

    function automatic logic [255:0] pack_line(input int ln);
        logic [255:0] l;
        for (int b = 0; b < 32; b++) l[255-8*b -: 8] = fmem[ln*32+b];
        return l;
    endfunction

    function automatic logic [63:0] exp_load(input int a, input logic dw);
        logic [63:0] r = '0;
        int base = dw ? (a & ~7) : (a & ~3);
        int n = dw ? 8 : 4;
        for (int b = 0; b < n; b++) r = {r[55:0], fmem[base+b]};
        return r;
    endfunction

    // Updates the model for one access and returns what the cache should do.
    task automatic model_op(input logic rd, input logic [1:0] wr, input logic dw, input int a,
                            input logic [63:0] wd, output bit miss, output bit vdirty,
                            output logic [63:0] rdata);
        int i = (a >> 5) & 7;
        logic [23:0] t = 24'(a >> 8);
        miss = !(cv[i] && ct[i] == t);
        vdirty = miss && cv[i] && cd[i];
        if (miss) begin
            cv[i] = 1'b1;
            ct[i] = t;
            cd[i] = 1'b0;
        end
        case (wr)
            2'd1: for (int k = 0; k < 4; k++) fmem[(a & ~3) + k] = wd[31-8*k -: 8];
            2'd2: fmem[a] = wd[7:0];
            2'd3: for (int k = 0; k < 8; k++) fmem[(a & ~7) + k] = wd[63-8*k -: 8];
            default: ;
        endcase
        if (wr != 2'd0) cd[i] = 1'b1;
        rdata = rd ? exp_load(a, dw) : 64'd0;
        exp_hits++;
        if (miss) exp_miss++;
    endtask

    // Called #1 after a posedge; returns #1 after the posedge that completes the access.
    task automatic do_access(input logic rd, input logic [1:0] wr, input logic dw, input int a,
                             input logic [63:0] wd, output int stalls, output logic [63:0] got);
        memread = rd;
        memwrite = wr;
        dword = dw;
        dataadr = 32'(a);
        writedata = wd;
        stalls = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ready) break;
            stalls++;
        end
        got = readdata;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL access_timeout addr=%h: ready=%b required 1", a, ready);
        end
        @(posedge clk);
        #1;
        memread = 1'b0;
        memwrite = 2'd0;
    endtask

    task automatic do_flush(output int cycles, output int pulses);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        cycles = 0;
        pulses = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            cycles++;
            if (flush_done) begin
                pulses++;
                break;
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (flush_done) pulses++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) cd[i] = 1'b0;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        memread = 1'b0;
        memwrite = 2'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cv[i] = 1'b0;
            cd[i] = 1'b0;
        end
        exp_hits = 0;
        exp_miss = 0;
    endtask

    task automatic test_reset;
        apply_reset();
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem: req=%b we=%b want 0 0", mem_req, mem_we);
        end
        checks++;
        if (flush_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush_done: got %b want 0", flush_done);
        end
        checks++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: hit=%0d miss=%0d want 0 0", hit_cnt, miss_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed;
        int st;
        bit miss, vd;
        logic [63:0] e, got;
        logic [255:0] wline;
        fill_addr_q.delete();
        model_op(1, 0, 1, 'h40, 0, miss, vd, e);
        do_access(1, 0, 1, 'h40, 0, st, got);
        checks++;
        if (st != 2) begin errors++; $display("FAIL cold_stall: got %0d want 2", st); end
        checks++;
        if (fill_addr_q.size() != 1 || fill_addr_q[0] !== 27'h2) begin
            errors++;
            $display("FAIL cold_fill_addr: fills=%0d want one at 0x2", fill_addr_q.size());
        end
        checks++;
        if (got !== 64'h1122334455667788) begin
            errors++;
            $display("FAIL cold_dword: got %h want 1122334455667788", got);
        end
        model_op(1, 0, 0, 'h44, 0, miss, vd, e);
        do_access(1, 0, 0, 'h44, 0, st, got);
        checks++;
        if (got !== 64'h0000000055667788 || st != 0) begin
            errors++;
            $display("FAIL hit_word: got %h stall %0d want 0000000055667788 stall 0", got, st);
        end
        model_op(0, 2, 0, 'h41, 64'hAB, miss, vd, e);
        do_access(0, 2, 0, 'h41, 64'hAB, st, got);
        checks++;
        if (st != 0) begin errors++; $display("FAIL byte_store_stall: got %0d want 0", st); end
        model_op(1, 0, 1, 'h40, 0, miss, vd, e);
        do_access(1, 0, 1, 'h40, 0, st, got);
        checks++;
        if (got !== 64'h11AB334455667788) begin
            errors++;
            $display("FAIL byte_merge: got %h want 11ab334455667788", got);
        end
        wline = pack_line(2);
        wb_addr_q.delete();
        wb_data_q.delete();
        fill_addr_q.delete();
        model_op(1, 0, 1, 'h140, 0, miss, vd, e);
        do_access(1, 0, 1, 'h140, 0, st, got);
        checks++;
        if (st != 3) begin errors++; $display("FAIL dirty_miss_stall: got %0d want 3", st); end
        checks++;
        if (wb_addr_q.size() != 1 || wb_addr_q[0] !== 27'h2 || wb_data_q[0] !== wline) begin
            errors++;
            $display("FAIL victim_wb: count %0d want one at 0x2 with line %h", wb_addr_q.size(),
                     wline);
        end
        checks++;
        if (fill_addr_q.size() != 1 || fill_addr_q[0] !== 27'hA) begin
            errors++;
            $display("FAIL refill_addr: fills=%0d want one at 0xa", fill_addr_q.size());
        end
        checks++;
        if (got !== e) begin errors++; $display("FAIL refill_data: got %h want %h", got, e); end
    endtask

    task automatic test_random;
        int st, a, bad_data = 0, bad_stall = 0;
        bit miss, vd, rd;
        logic [1:0] wr;
        logic dw;
        logic [63:0] wd, e, got;
        ack_wait_max = 3;
        for (int n = 0; n < 300; n++) begin
            a = int'($urandom_range(1023, 0));
            rd = $urandom_range(1, 0) == 1;
            wr = rd ? 2'd0 : 2'($urandom_range(3, 1));
            dw = 1'($urandom);
            wd = {$urandom, $urandom};
            model_op(rd, wr, dw, a, wd, miss, vd, e);
            do_access(rd, wr, dw, a, wd, st, got);
            checks++;
            if (rd && got !== e) begin
                errors++;
                bad_data++;
                if (bad_data < 5) $display("FAIL rand_load a=%h: got %h want %h", a, got, e);
            end
            checks++;
            if ((!miss && st != 0) || (miss && !vd && st < 2) || (vd && st < 3)) begin
                errors++;
                bad_stall++;
                if (bad_stall < 5)
                    $display("FAIL rand_stall a=%h: got %0d for miss=%0d dirty=%0d", a, st, miss,
                             vd);
            end
        end
        ack_wait_max = 0;
        cur_wait = 0;
`ifdef DCACHE_STATS_EN
        checks++;
        if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_miss)) begin
            errors++;
            $display("FAIL rand_counters: hit=%0d miss=%0d want %0d %0d", hit_cnt, miss_cnt,
                     exp_hits, exp_miss);
        end
`else
        checks++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            errors++;
            $display("FAIL counters_tied: hit=%0d miss=%0d want 0 0", hit_cnt, miss_cnt);
        end
`endif
    endtask

    task automatic test_flush;
        int cyc, pulses, nd = 0, bad = 0, st;
        bit miss, vd;
        logic [63:0] e, got;
        logic [26:0] exp_wb [$];
        for (int i = 0; i < 8; i++)
            if (cv[i] && cd[i]) begin
                nd++;
                exp_wb.push_back({ct[i], 3'(i)});
            end
        wb_addr_q.delete();
        do_flush(cyc, pulses);
        checks++;
        if (pulses != 1 || cyc != 8 + nd) begin
            errors++;
            $display("FAIL flush_all: cycles %0d pulses %0d want %0d 1", cyc, pulses, 8 + nd);
        end
        checks++;
        if (wb_addr_q != exp_wb) begin
            errors++;
            $display("FAIL flush_all_order: %0d write-backs want %0d", wb_addr_q.size(), nd);
        end
        for (int l = 0; l < 32; l++) if (bmem[l] !== pack_line(l)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL flush_mem: %0d stale lines want 0", bad); end

        model_op(0, 2, 0, 'h21, 64'h5A, miss, vd, e);
        do_access(0, 2, 0, 'h21, 64'h5A, st, got);
        model_op(0, 1, 0, 'hA4, 64'hCAFEF00D, miss, vd, e);
        do_access(0, 1, 0, 'hA4, 64'hCAFEF00D, st, got);
        wb_addr_q.delete();
        do_flush(cyc, pulses);
        checks++;
        if (cyc != 10 || pulses != 1) begin
            errors++;
            $display("FAIL flush_two: cycles %0d pulses %0d want 10 1", cyc, pulses);
        end
        checks++;
        if (wb_addr_q.size() != 2 || wb_addr_q[0] !== {ct[1], 3'd1} ||
            wb_addr_q[1] !== {ct[5], 3'd5}) begin
            errors++;
            $display("FAIL flush_two_order: %0d write-backs want lines 1 then 5", wb_addr_q.size());
        end
        checks++;
        if (bmem[1] !== pack_line(1) || bmem[5] !== pack_line(5)) begin
            errors++;
            $display("FAIL flush_two_data: got %h want %h", bmem[1], pack_line(1));
        end
        model_op(1, 0, 1, 'h20, 0, miss, vd, e);
        do_access(1, 0, 1, 'h20, 0, st, got);
        checks++;
        if (st != 0 || got !== e) begin
            errors++;
            $display("FAIL flush_keeps_valid: stall %0d data %h want 0 %h", st, got, e);
        end
    endtask

    task automatic test_reset_mid_fill;
        int a, st;
        bit seen = 1'b0, miss, vd;
        logic [63:0] e, got;
        logic [23:0] t;
        t = cv[2] ? ((ct[2] + 24'd1) & 24'd3) : 24'd0;
        a = int'({t, 3'd2, 5'd0});
        hold_ack = 1'b1;
        memread = 1'b1;
        dword = 1'b1;
        dataadr = 32'(a);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL fill_start: mem_req=0 want 1"); end
        reset = 1'b1;
        memread = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        hold_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cv[i] = 1'b0;
            cd[i] = 1'b0;
        end
        exp_hits = 0;
        exp_miss = 0;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_abandon: req=%b want 0", mem_req); end
        model_op(1, 0, 1, a, 0, miss, vd, e);
        do_access(1, 0, 1, a, 0, st, got);
        checks++;
        if (st != 2 || got !== e) begin
            errors++;
            $display("FAIL reload_after_reset: stall %0d data %h want 2 %h", st, got, e);
        end
    endtask

    task automatic test_stats;
        int st;
        bit miss, vd;
        logic [63:0] e, got;
        int seq [5] = '{'h48, 'h48, 'h68, 'h68, 'h48};
        apply_reset();
        foreach (seq[k]) begin
            model_op(1, 0, 1, seq[k], 0, miss, vd, e);
            do_access(1, 0, 1, seq[k], 0, st, got);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL stats_load%0d: got %h want %h", k, got, e);
            end
        end
`ifdef DCACHE_STATS_EN
        checks++;
        if (hit_cnt !== 32'd5 || miss_cnt !== 32'd2) begin
            errors++;
            $display("FAIL stats_counts: hit=%0d miss=%0d want 5 2", hit_cnt, miss_cnt);
        end
`else
        checks++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            errors++;
            $display("FAIL stats_tied: hit=%0d miss=%0d want 0 0", hit_cnt, miss_cnt);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) fmem[i] = 8'($urandom);
        for (int k = 0; k < 8; k++) fmem['h40 + k] = 8'(8'h11 * (k + 1));
        for (int l = 0; l < 32; l++) bmem[l] = pack_line(l);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid_fill();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_wb.md
# dcache_wb

Parametrised direct-mapped write-back data cache between the pipeline's memory stage and the line-wide backing memory. Generalises the fixed 8-line cache to configurable data width, line count and line length. Adds:
- a registered miss state machine with an explicit req/ack memory handshake;
- write-back of dirty victims before refill;
- a whole-cache flush sequence.

Hits complete in the request cycle. Misses stall the pipeline through `ready`.

## Interface
- `N`, 64: data width in bits; must be 64 (dword) in this generation.
- `ADDR`, 32: byte address width.
- `LINES`, 8: number of cache lines; power of two, ≥2.
- `WORDS`, 4: N-bit words per line; power of two, ≥2.
- Derived values:
  - OFF = log2(N/8·WORDS), 5 by default.
  - IDX = log2(LINES).
  - TAG = ADDR−OFF−IDX.
  - LW = N·WORDS.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `memread` in 1: load request.
- `memwrite` in 2: 0 none, 1 word (32b), 2 byte, 3 dword.
- `dword` in 1: load returns full 64b when 1, else zero-extended 32b word.
- `dataadr` in ADDR: byte address.
- `writedata` in N: store data, right-aligned.
- `readdata` out N: load data, combinational on hit.
- `ready` out 1: 1 = current request completes this cycle (or no request pending).
- `flush` in 1: start write-back of all dirty lines; sampled in IDLE only.
- `flush_done` out 1: one-cycle pulse when flush finishes.
- `mem_req` out 1, `mem_we` out 1: line transfer request; mem_we=1 is write-back, 0 is fill.
- `mem_addr` out ADDR−OFF: line address.
- `mem_wdata` out LW, `mem_rdata` in LW: line data.
- `mem_ack` in 1: one-cycle completion strobe from memory.

## Operation
- Address split: tag=`dataadr[ADDR-1:OFF+IDX]`, index=`[OFF+IDX-1:OFF]`, word=`[OFF-1:3]`.
- Per-line state: valid, dirty, tag, LW data. Data is not reset.
- Layout is big-endian:
  - word 0 occupies line MSBs;
  - within a dword, `dataadr[2]`=0 selects [63:32];
  - byte offset 0 selects [63:56].
- Request is active when `memread` or `memwrite`≠0; both never set together. Hit = valid[index] && tag match.
- States:
  - IDLE
    - Hit, or no request: `ready`=1.
    - Hit store: merges byte/word/dword into the line at posedge and sets dirty.
    - Miss: `ready`=0. Goes to WB if the victim is valid&&dirty, else FILL.
    - `flush`=1 with no request: goes to FLUSH with index counter=0. A request in the same cycle has priority and flush is ignored.
  - WB: `mem_req`=1, `mem_we`=1, `mem_addr`={victim tag,index}, `mem_wdata`=line. On `mem_ack`: clear dirty, go to FILL.
  - FILL: `mem_req`=1, `mem_we`=0, `mem_addr`=`dataadr[ADDR-1:OFF]`. On `mem_ack`: write `mem_rdata`, set valid, set tag, clear dirty, go to IDLE. The re-lookup then hits.
  - FLUSH: scan index 0..LINES−1.
    - Dirty line: write-back handshake as in WB, then clear dirty.
    - Clean line: advance one per cycle.
    - After the last index: pulse `flush_done`, return to IDLE. Valid bits are kept.
- The CPU holds all request inputs stable while `ready`=0.

## Timing
- Reset values:
  - state IDLE; all valid and dirty bits 0;
  - `mem_req`=0, `mem_we`=0, `flush_done`=0;
  - `ready`=1 when no request is pending.
- Hit latency is 0: `readdata`/`ready` are combinational in the request cycle; the store commits at the next posedge.
- Miss latency in stall cycles:
  - clean victim: 1 + fill wait;
  - dirty victim: 1 + write-back wait + fill wait.
  - With `mem_ack` in the first req cycle: clean = 2 stall cycles, dirty = 3.
- `mem_req` and `mem_addr`/`mem_wdata` are registered and held stable until the `mem_ack` cycle. They deassert in the cycle after ack unless the next transfer begins.
- `mem_ack` while `mem_req`=0 is ignored.
- Reset mid-transfer abandons it: `mem_req` is 0 after the reset edge. The memory must tolerate a dropped request.
- Flush takes LINES + Σ(write-back waits) cycles; `ready`=0 throughout.

## Configuration
- `DCACHE_STATS_EN`
  - Defined: adds outputs `hit_cnt`, `miss_cnt` (32b each, reset to 0, saturating at all-ones).
    - `hit_cnt` increments on each completed hit-cycle request.
    - `miss_cnt` increments once per IDLE→WB/FILL transition.
    - The re-lookup after a fill counts as a hit.
  - Undefined: ports exist but are tied to 0; no counter logic.

## Test plan
- Cold load `dataadr`=0x40 → `ready` low, FILL with `mem_addr`=0x2; ack with line word0=0x1122334455667788. Next cycle `ready`=1. With `dword`=1, `readdata`=0x1122334455667788. With `dword`=0 and addr 0x44, `readdata`=0x0000000055667788.
- Byte store 0xAB to 0x41 on a hit line → same line reads 0x11AB334455667788; line dirty.
- Load 0x140 (same index, new tag) after the dirty store → WB to `mem_addr`=0x2 with the modified line, then FILL at 0xA. With immediate acks, `ready` is low exactly 3 cycles.
- Flush with dirty lines 1 and 5 → exactly two write-backs, in index order. `flush_done` pulses once after index 7; valid bits unchanged.
- Assert `reset` during FILL before ack → `mem_req`=0 next cycle. A subsequent load of the same address misses again.
- With `DCACHE_STATS_EN`: 3 hits and 2 misses give `hit_cnt`=5 (including the 2 re-lookups) and `miss_cnt`=2.
